// File: rtl/a5_1_byte_xor.sv
// Packs the A5/1 keystream into bytes and XORs them with a pixel stream.
// Stalls the generator instead of dropping bits under backpressure.
module a5_1_byte_xor #(
  parameter int NUM_BYTES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gen_load,
  output logic       gen_en,
  input  logic       ks_bit,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    ks_byte_q, ks_byte_d;
  logic          ks_full_q, ks_full_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;

  logic in_run;
  logic consume;
  logic complete;

  always_comb begin
    in_run   = (state_q == RUN);
    s_ready  = in_run & ks_full_q & (~m_valid_q | m_ready);
    consume  = s_valid & s_ready;
    gen_en   = in_run
             & ~((bit_cnt_q == 3'd7) & ks_full_q & ~consume);
    complete = gen_en & (bit_cnt_q == 3'd7);
  end

  assign gen_load = (state_q == LOAD);
  assign busy     = (state_q == LOAD) | (state_q == RUN);
  assign done     = (state_q == FIN);
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    ks_byte_d  = ks_byte_q;
    ks_full_d  = ks_full_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    byte_cnt_d = byte_cnt_q;

    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (consume && byte_cnt_q == LAST) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (gen_en) begin
      sr_d[bit_cnt_q] = ks_bit;
      bit_cnt_d       = bit_cnt_q + 3'd1;
    end

    if (consume) begin
      m_data_d  = s_data ^ ks_byte_q;
      ks_full_d = 1'b0;
    end

    // gen_en guarantees the slot is free or being emptied here
    if (complete) begin
      ks_byte_d = {ks_bit, sr_q[6:0]};
      ks_full_d = 1'b1;
    end

    if (consume) m_valid_d = 1'b1;
    else if (m_ready) m_valid_d = 1'b0;

    if (state_q == IDLE && start) byte_cnt_d = '0;
    else if (consume) byte_cnt_d = byte_cnt_q + CW'(1);

    if (state_q == FIN) begin
      sr_d      = '0;
      bit_cnt_d = '0;
      ks_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      ks_byte_q  <= '0;
      ks_full_q  <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      ks_byte_q  <= ks_byte_d;
      ks_full_q  <= ks_full_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_a5_1_byte_xor.sv
// Scoreboard bench for a5_1_byte_xor with a behavioural keystream source.
// Four-byte runs cover packing, stalls, run length and async reset.
module tb_a5_1_byte_xor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       gen_load;
  logic       gen_en;
  logic       ks_bit;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  a5_1_byte_xor #(.NUM_BYTES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .gen_load (gen_load),
    .gen_en   (gen_en),
    .ks_bit   (ks_bit),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // first eight bits are 1,0,1,1,0,0,1,0 -> 0x4D
  logic [63:0] kseq = 64'h9E37_79B9_7F4A_7C4D;
  logic [5:0]  gidx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gidx <= '0;
    else if (gen_load) gidx <= '0;
    else if (gen_en) gidx <= gidx + 6'd1;
  end

  assign ks_bit = kseq[gidx];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb[$];
  int cons_run   = 0;
  int cons_total = 0;
  int loads      = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (gen_load) begin
        cons_run = 0;
        loads++;
      end
      if (s_valid && s_ready) begin
        sb.push_back(s_data ^ kseq[8*cons_run +: 8]);
        cons_run++;
        cons_total++;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("m_data", m_data, sb.pop_front());
      end
    end
  end

  logic       sv_en = 1'b0;
  logic       mr_en = 1'b0;
  logic       rnd   = 1'b0;
  logic [7:0] base  = 8'hFF;
  int         scr   = 0;

  initial begin
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      s_data  = base ^ 8'(cons_total * scr);
      s_valid = sv_en && (!rnd || $urandom_range(3) != 0);
      m_ready = mr_en && (!rnd || $urandom_range(3) != 0);
    end
  end

  task automatic start_run();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("done_width", done, 0);
      chk("idle_after", {busy, s_ready}, 0);
    end
    mr_en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  int n;
  int l0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {gen_load, gen_en, s_ready, m_valid, busy, done}, 0);
    chk("reset_data", m_data, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // bit packing and start-up latency
    sv_en = 1'b1;
    mr_en = 1'b1;
    start_run();
    @(negedge clk);
    n = 1;
    chk("load_pulse", {gen_load, gen_en}, 2'b10);
    @(negedge clk);
    n = 2;
    chk("en_after_load", {gen_load, gen_en}, 2'b01);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_lat", n, 10);
    @(negedge clk);
    chk("first_valid", m_valid, 1);
    chk("first_byte", m_data, 8'hB2);
    wait_done(100);

    // random handshakes, start ignored mid-run
    scr  = 37;
    base = 8'h5A;
    rnd  = 1'b1;
    l0   = loads;
    start_run();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(300);
    chk("one_load", loads - l0, 1);
    rnd = 1'b0;

    // output backpressure
    base = 8'h3C;
    start_run();
    n = 0;
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_valid", m_valid, 1);
    mr_en = 1'b0;
    repeat (40) @(negedge clk);
    chk("bp_gen_stall", gen_en, 0);
    chk("bp_bits", gidx, 8 * cons_run + 15);
    mr_en = 1'b1;
    wait_done(200);

    // input starvation
    base = 8'hC3;
    start_run();
    n = 0;
    while (cons_run < 2 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("st_progress", cons_run >= 2, 1);
    sv_en = 1'b0;
    repeat (30) @(negedge clk);
    chk("st_gen_stall", gen_en, 0);
    chk("st_bits", gidx, 8 * cons_run + 15);
    sv_en = 1'b1;
    wait_done(200);

    // asynchronous reset with a byte held in the output
    mr_en = 1'b0;
    start_run();
    n = 0;
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl",
        {gen_load, gen_en, s_ready, m_valid, busy, done}, 0);
    chk("rst_async_data", m_data, 8'h00);
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mr_en = 1'b1;
    @(negedge clk);
    chk("rst_idle", busy, 0);
    start_run();
    @(negedge clk);
    chk("rst_reload", gen_load, 1);
    wait_done(100);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
